hazard_bubble_unit: RTL
=======================

# hazard_bubble_unit

Parametrised pipeline hazard controller that supersedes the single-cycle control-zeroing mux in the 5-stage CPU. It sits between the ID stage and the ID/EX register. It detects load-use hazards and inserts `STALL_CYC` consecutive bubbles by zeroing an arbitrary-width control bundle. It also freezes the front end on data-memory stalls and flushes IF/ID on taken branches, and its stall length is held by an internal FSM and counter rather than a pure combinational gate.

## Interface
Parameters:
- `CTRL_W`, 6: width of the control bundle passed ID→EX.
- `REG_AW`, 5: register-address width.
- `STALL_CYC`, 1: bubbles per load-use hazard. Legal range 1..15.

Ports:
- `clk_i` input 1: clock, rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `ctrl_i` input `CTRL_W`: control bundle from the decoder.
- `idex_memread_i` input 1: the instruction in EX is a load.
- `idex_rt_i` input `REG_AW`: destination of the load in EX.
- `ifid_rs_i` input `REG_AW`: rs of the instruction in ID.
- `ifid_rt_i` input `REG_AW`: rt of the instruction in ID.
- `ifid_uses_rt_i` input 1: the ID instruction reads rt as a source.
- `branch_taken_i` input 1: a branch resolved as taken in ID.
- `mem_stall_i` input 1: the data memory is not ready, so the whole pipeline holds.
- `ctrl_o` output `CTRL_W`: either `ctrl_i` or all-zero (bubble).
- `pc_write_o` output 1: PC update enable.
- `ifid_write_o` output 1: IF/ID register enable.
- `idex_write_o` output 1: ID/EX register enable.
- `ifid_flush_o` output 1: clear IF/ID to a NOP.
- `busy_o` output 1: a multi-cycle bubble sequence is in progress.
- `stat_bubbles_o` output 32: number of bubbles inserted (see Configuration).

## Operation
- Hazard condition: `idex_memread_i && idex_rt_i != 0 && (idex_rt_i == ifid_rs_i || (ifid_uses_rt_i && idex_rt_i == ifid_rt_i))`.
- The FSM has three states: `RUN`, `STALL`, `HOLD`. A counter `cnt` of `$clog2(STALL_CYC+1)` bits tracks the remaining bubbles.
- `run_q` is a register that is 0 during reset and sets to 1 on the first clock edge after reset releases.
  - While `run_q` = 0, all outputs are 0, including the write enables.
- Priority, highest first: `mem_stall_i`, then an active bubble sequence, then a new hazard, then `branch_taken_i`.
- `mem_stall_i` = 1, in any state:
  - `pc_write_o`, `ifid_write_o`, `idex_write_o` are 0 and `ifid_flush_o` is 0.
  - `ctrl_o` = `ctrl_i`.
  - `cnt` holds. The FSM records its return state and moves to `HOLD`, then returns to that state when `mem_stall_i` drops.
- `RUN` with a hazard:
  - `ctrl_o` = 0, `pc_write_o` = 0, `ifid_write_o` = 0, `idex_write_o` = 1.
  - If `STALL_CYC` > 1: next state is `STALL` and `cnt` is loaded with `STALL_CYC-1`. Otherwise the FSM stays in `RUN`.
- `STALL`:
  - Same outputs as a hazard cycle in `RUN`; `busy_o` = 1.
  - `cnt` decrements each cycle; on the cycle with `cnt` == 1 the next state is `RUN`.
  - Hazard inputs and `branch_taken_i` are ignored.
- `RUN`, no hazard, `branch_taken_i` = 1:
  - `ifid_flush_o` = 1 and all write enables are 1.
  - `ctrl_o` = `ctrl_i`; the branch itself proceeds.
- A hazard together with `branch_taken_i` = 1: the bubble wins and the flush is suppressed. The branch's operands are not yet valid, so the branch re-resolves after the stall.
- `RUN`, idle: `ctrl_o` = `ctrl_i`, all write enables are 1, `ifid_flush_o` = 0.

## Timing
- Reset values:
  - State `RUN`, `cnt` = 0, `run_q` = 0, `stat_bubbles_o` = 0.
  - All outputs are 0 while `rst_i` = 0.
- Outputs are combinational from the state plus the current inputs, so a hazard or flush takes effect in the same cycle as detection (0 latency).
- A hazard detected in cycle N produces bubbles in cycles N..N+`STALL_CYC`-1. `pc_write_o` returns to 1 in cycle N+`STALL_CYC`.
- Cycles spent in `mem_stall_i` extend this window one-for-one.
- Asserting reset mid-`STALL` returns the unit to `RUN` immediately; no bubble sequence resumes after release.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stat_bubbles_o` is a 32-bit saturating counter.
  - It increments on every clock where `ctrl_o` is forced to zero and `idex_write_o` = 1.
  - It is cleared only by reset.
- `HAZARD_STATS_EN` undefined: `stat_bubbles_o` is tied to 0 and no counter flops are built.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - `CTRL_W`;
  - the control-bit index constants (RegDst, ALUOp, ALUSrc, RegWrite, MemToReg, MemWrite);
  - the FSM state enum `hz_state_t`.
- Sub-module `hazard_detect`: purely combinational register-address compare that produces the hazard flag. It is reused by the forwarding unit.

## Test plan
- `STALL_CYC`=1: load `$2` in EX, ID reads rs=`$2`, `ctrl_i`=6'h3F → `ctrl_o`=0 and `pc_write_o`=0 for exactly 1 cycle, then `ctrl_o`=6'h3F.
- `STALL_CYC`=3: same hazard → 3 bubble cycles, `busy_o`=1 for cycles 2–3, `pc_write_o`=1 on cycle 4. With `HAZARD_STATS_EN`, `stat_bubbles_o`=3.
- `idex_rt_i`=0 matching `ifid_rs_i`=0 → no bubble; rt match with `ifid_uses_rt_i`=0 → no bubble.
- Hazard and `branch_taken_i`=1 in the same cycle → bubble, `ifid_flush_o`=0. A later taken branch with no hazard → `ifid_flush_o`=1 for 1 cycle.
- `STALL_CYC`=3: `mem_stall_i`=1 for 2 cycles in the middle of `STALL` → all write enables 0, `cnt` frozen, total bubble window 5 cycles.
- `rst_i` asserted during `STALL` → all outputs 0. After release: the first cycle has outputs 0, then `RUN` with no residual bubbles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-bundle layout and hazard FSM states for the 5-stage CPU.
package cpu_ctrl_pkg;
    localparam int CTRL_WIDTH = 6;
    localparam int CTRL_REG_DST = 0;
    localparam int CTRL_ALU_OP = 1;
    localparam int CTRL_ALU_SRC = 2;
    localparam int CTRL_REG_WRITE = 3;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_MEM_WRITE = 5;
    typedef enum logic [1:0] {RUN, STALL, HOLD} hz_state_t;
endpackage

// File: rtl/hazard_bubble_unit_if.sv
// hazard_bubble_unit_if: ID-stage control, hazard operands and pipeline enables.
interface hazard_bubble_unit_if #(parameter int CTRL_W = 6, parameter int REG_AW = 5);
    logic [CTRL_W-1:0] ctrl_i;
    logic idex_memread_i;
    logic [REG_AW-1:0] idex_rt_i;
    logic [REG_AW-1:0] ifid_rs_i;
    logic [REG_AW-1:0] ifid_rt_i;
    logic ifid_uses_rt_i;
    logic branch_taken_i;
    logic mem_stall_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic pc_write_o;
    logic ifid_write_o;
    logic idex_write_o;
    logic ifid_flush_o;
    logic busy_o;
    logic [31:0] stat_bubbles_o;
    modport master (
        output ctrl_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
               branch_taken_i, mem_stall_i,
        input ctrl_o, pc_write_o, ifid_write_o, idex_write_o, ifid_flush_o, busy_o, stat_bubbles_o
    );
    modport slave (
        input ctrl_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i, ifid_uses_rt_i,
              branch_taken_i, mem_stall_i,
        output ctrl_o, pc_write_o, ifid_write_o, idex_write_o, ifid_flush_o, busy_o, stat_bubbles_o
    );
endinterface

// File: rtl/hazard_detect.sv
// hazard_detect: load-use register-address compare, shared with the forwarding unit.
module hazard_detect #(parameter int REG_AW = 5) (
    input  logic              memRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              usesRt,
    output logic              hazard
);
    assign hazard = memRead && exRt != '0 && (exRt == idRs || (usesRt && exRt == idRt));
endmodule

// File: rtl/hazard_bubble_unit.sv
// hazard_bubble_unit: multi-cycle load-use bubbles, memory-stall freeze and branch flush.
// Define HAZARD_STATS_EN to build the saturating bubble counter on stat_bubbles_o.
module hazard_bubble_unit import cpu_ctrl_pkg::*; #(
    parameter int CTRL_W = CTRL_WIDTH,
    parameter int REG_AW = 5,
    parameter int STALL_CYC = 1
) (
    input logic clk_i,
    input logic rst_i,
    hazard_bubble_unit_if.slave bus
);
    localparam int CW = $clog2(STALL_CYC + 1);
    hz_state_t state, nextState, retQ, retNext, eff;
    logic [CW-1:0] cnt, cntNext;
    logic [CTRL_W-1:0] ctrlPass;
    logic runQ, hazard, bubble, holdAll, flush;

    hazard_detect #(.REG_AW(REG_AW)) uDetect (
        .memRead(bus.idex_memread_i),
        .exRt(bus.idex_rt_i),
        .idRs(bus.ifid_rs_i),
        .idRt(bus.ifid_rt_i),
        .usesRt(bus.ifid_uses_rt_i),
        .hazard(hazard)
    );

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state <= RUN;
            retQ <= RUN;
            cnt <= '0;
            runQ <= 1'b0;
        end else begin
            state <= nextState;
            retQ <= retNext;
            cnt <= cntNext;
            runQ <= 1'b1;
        end

    // HOLD behaves like the state it interrupted once the memory stall clears
    always_comb begin
        eff = (state == HOLD) ? retQ : state;
        nextState = state;
        retNext = retQ;
        cntNext = cnt;
        bubble = 1'b0;
        holdAll = 1'b0;
        flush = 1'b0;
        if (runQ) begin
            if (bus.mem_stall_i) begin
                holdAll = 1'b1;
                nextState = HOLD;
                retNext = eff;
            end else if (eff == STALL) begin
                bubble = 1'b1;
                cntNext = cnt - CW'(1);
                nextState = (cnt == CW'(1)) ? RUN : STALL;
            end else if (hazard) begin
                bubble = 1'b1;
                nextState = (STALL_CYC > 1) ? STALL : RUN;
                cntNext = (STALL_CYC > 1) ? CW'(STALL_CYC - 1) : cnt;
            end else begin
                nextState = RUN;
                flush = bus.branch_taken_i;
            end
        end
    end

    assign ctrlPass = bus.ctrl_i;
    assign bus.ctrl_o = (!runQ || bubble) ? '0 : ctrlPass;
    assign bus.pc_write_o = runQ && !holdAll && !bubble;
    assign bus.ifid_write_o = runQ && !holdAll && !bubble;
    assign bus.idex_write_o = runQ && !holdAll;
    assign bus.ifid_flush_o = flush;
    assign bus.busy_o = runQ && eff == STALL;

`ifdef HAZARD_STATS_EN
    logic [31:0] statQ;
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) statQ <= '0;
        else if (bubble && statQ != '1) statQ <= statQ + 32'd1;
    assign bus.stat_bubbles_o = statQ;
`else
    assign bus.stat_bubbles_o = '0;
`endif
endmodule
